out_port_alloc: RTL and testbench
=================================

# out_port_alloc

Per-output-port wormhole allocator for the 5-port (N, S, E, W, L) NoC router. It arbitrates round-robin among input ports requesting this output, locks the grant for the full packet (head to tail), and gates every flit transfer on downstream buffer credits. One instance sits beside each crossbar output; its grant index drives that output's crossbar mux select.

## Interface
Parameters:
- NUM_PORTS, 5, number of requesting input ports; index order N=0, S=1, E=2, W=3, L=4
- CREDIT_DEPTH, 4, downstream input-buffer depth in flits; credit counter reset value
- CW, $clog2(CREDIT_DEPTH+1), credit counter width

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous and active-low
- req_i  input  NUM_PORTS  bit i: input port i has a head-of-queue flit destined for this output
- tail_i  input  NUM_PORTS  bit i: that flit is a tail flit; a single-flit packet has head and tail set
- credit_return_i  input  1  downstream freed one buffer slot this cycle
- grant_o  output  NUM_PORTS  one-hot; bit i = flit from port i traverses the crossbar this cycle
- grant_idx_o  output  3  index of granted port; 3'b111 when no grant
- locked_o  output  1  a packet currently owns the output
- credits_o  output  CW  current credit count
- credit_err_o  output  1  sticky credit-protocol error (see Configuration)

## Operation
- State: fsm {IDLE, LOCKED}, owner[2:0], rr_ptr[2:0] (last winner), credits[CW-1:0].
- A transfer occurs in a cycle where grant_o != 0. Grant requires credits > 0, evaluated on the registered count.
- IDLE: if credits > 0 and req_i != 0, grant the first set req_i bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Winner's tail_i set: stay IDLE, rr_ptr <= winner.
  - Otherwise: go to LOCKED, owner <= winner.
- LOCKED: grant only owner, and only when req_i[owner] and credits > 0. Other requests are ignored. A bubble (req_i[owner]=0) holds the lock.
  - Transfer with tail_i[owner]: go to IDLE, rr_ptr <= owner.
- Credits: decrement on transfer; increment on credit_return_i; both in one cycle leaves the count unchanged.
- Return at credits == CREDIT_DEPTH with no transfer: the count saturates and holds.
- Zero credits: no grant and no state change. The lock persists.
- locked_o = (fsm == LOCKED). grant_idx_o = encoded grant_o, or 3'b111 when grant_o == 0.

## Timing
- Reset values: fsm IDLE, owner 0, rr_ptr NUM_PORTS-1 (port 0 first priority), credits CREDIT_DEPTH, credit_err_o 0. All outputs derived from these: grant_o 0 with no requests, grant_idx_o 3'b111, locked_o 0, credits_o CREDIT_DEPTH.
- grant_o and grant_idx_o are combinational from req_i, tail_i and registered state, giving zero-cycle grant latency. All state updates at the rising clk edge.
- The tail cycle releases the lock. The earliest new arbitration is the next cycle, so there is no same-cycle re-grant.
- A credit returned in cycle t is usable in cycle t+1.
- rst low mid-packet: the lock is dropped and credits are restored. Upstream and downstream must reset together.

## Configuration
- OUT_ALLOC_CREDIT_CHECK_EN defined: credit_err_o is set and held until reset when either of these occurs:
  - credit_return_i at credits == CREDIT_DEPTH without a same-cycle transfer;
  - req_i has a bit set outside the owner while LOCKED and tail_i[owner] is set for a non-requesting owner.
- Not defined: credit_err_o is tied 0 and the checking logic is omitted. All other behaviour is identical.

## Structure
- noc_pkg holds:
  - port index enum (PORT_N=0 … PORT_L=4);
  - NO_GRANT = 3'b111;
  - alloc_state_t {IDLE, LOCKED}.
- Sub-module rr_pick: combinational, NUM_PORTS-parameterized. Inputs are a request vector and the last-winner pointer; outputs are a one-hot winner and its index. It is reusable by the virtual-channel allocator.

## Test plan
- Reset, then req_i=5'b00110 with tail_i=5'b00110 for 4 cycles, credits returned each cycle. Grants alternate S(1), E(2), S, E; credits_o stays 4.
- Port W sends a 3-flit packet (tail on flit 3) while N requests continuously. W is granted 3 consecutive cycles with locked_o=1; N is granted in the 4th cycle.
- 6 single-flit requests from L with no credit_return_i. Grants occur in 4 cycles, then grant_idx_o=3'b111 and credits_o=0. One return gives one more grant the following cycle.
- Transfer and credit_return_i in the same cycle at credits=1: credits_o stays 1 and the next grant is allowed.
- Reset asserted mid-packet (LOCKED, owner=E, credits=1). Next cycle: locked_o=0, credits_o=4, and N is granted first when all ports request.
- With OUT_ALLOC_CREDIT_CHECK_EN defined, credit_return_i at credits=4 sets credit_err_o=1, which stays 1 until reset while credits_o stays 4.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router types: input-port indices, the "no grant" index code and
// the output-allocator state encoding.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam logic [2:0] NO_GRANT = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches last_i+1, last_i+2, ... modulo
// NUM_PORTS and returns the first requester as a one-hot vector plus its index
// (NO_GRANT when nothing requests). Shared with the virtual-channel allocator.
module rr_pick
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = 5
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [2:0]           last_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [2:0]           gnt_idx_o
);

  logic [2:0] cand;
  logic       found;

  // Walk the ports in priority order starting just after the last winner.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = NO_GRANT;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = 3'((int'(last_i) + k) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/out_port_alloc.sv
// Per-output wormhole allocator: round-robin arbitration among inputs, grant
// locked from head to tail flit, every transfer gated on downstream credits.
// Optional feature: define OUT_ALLOC_CREDIT_CHECK_EN to build the sticky
// credit-protocol error flag; otherwise credit_err_o is tied low.
module out_port_alloc
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int CREDIT_DEPTH = 4,
  parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] tail_i,
  input  logic                 credit_return_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [2:0]           grant_idx_o,
  output logic                 locked_o,
  output logic [CW-1:0]        credits_o,
  output logic                 credit_err_o
);

  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_DEPTH);
  localparam logic [CW-1:0] CRED_ONE  = CW'(1);

  alloc_state_t         fsm_q, fsm_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        credits_q, credits_d;

  logic [NUM_PORTS-1:0] pick_gnt;
  logic [2:0]           pick_idx;
  logic [NUM_PORTS-1:0] owner_oh;
  logic                 has_credit;
  logic [NUM_PORTS-1:0] grant;
  logic [2:0]           grant_idx;
  logic                 xfer;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_pick (
    .req_i     (req_i),
    .last_i    (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx)
  );

  assign owner_oh   = NUM_PORTS'(1) << owner_q;
  assign has_credit = (credits_q != '0);
  assign xfer       = |grant;

  // Zero-latency grant: arbitration winner when idle, the owner when locked.
  always_comb begin
    grant     = '0;
    grant_idx = NO_GRANT;
    if (has_credit) begin
      if (fsm_q == IDLE) begin
        grant     = pick_gnt;
        grant_idx = pick_idx;
      end else if (req_i[owner_q]) begin
        grant     = owner_oh;
        grant_idx = owner_q;
      end
    end
  end

  // Lock on a non-tail head, release on the owner's tail, move the RR pointer.
  always_comb begin
    fsm_d    = fsm_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (fsm_q == IDLE) begin
        if (tail_i[pick_idx]) begin
          rr_ptr_d = pick_idx;
        end else begin
          fsm_d   = LOCKED;
          owner_d = pick_idx;
        end
      end else if (tail_i[owner_q]) begin
        fsm_d    = IDLE;
        rr_ptr_d = owner_q;
      end
    end
  end

  // Credit count: spend on transfer, refill on return, saturate at full.
  always_comb begin
    credits_d = credits_q;
    unique case ({xfer, credit_return_i})
      2'b10:   credits_d = credits_q - CRED_ONE;
      2'b01:   if (credits_q != CRED_FULL) credits_d = credits_q + CRED_ONE;
      default: credits_d = credits_q;
    endcase
  end

  // Allocator state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q     <= IDLE;
      owner_q   <= 3'(PORT_N);
      rr_ptr_q  <= 3'(NUM_PORTS - 1);
      credits_q <= CRED_FULL;
    end else begin
      fsm_q     <= fsm_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
    end
  end

`ifdef OUT_ALLOC_CREDIT_CHECK_EN
  logic err_q, err_d;
  logic other_req;

  // Flag a return into a full counter, or a tail marked on a bubbling owner
  // while another input is waiting.
  always_comb begin
    other_req = |(req_i & ~owner_oh);
    err_d     = err_q;
    if (credit_return_i && (credits_q == CRED_FULL) && !xfer) err_d = 1'b1;
    if ((fsm_q == LOCKED) && other_req && tail_i[owner_q] && !req_i[owner_q]) err_d = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign credit_err_o = err_q;
`else
  assign credit_err_o = 1'b0;
`endif

  assign grant_o     = grant;
  assign grant_idx_o = grant_idx;
  assign locked_o    = (fsm_q == LOCKED);
  assign credits_o   = credits_q;

endmodule

// File: tb/tb_out_port_alloc.sv
// Bench for out_port_alloc: directed scenarios plus a randomized run, all
// checked against a behavioural allocator model kept in this file.
module tb_out_port_alloc;

  localparam int NP    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] tail = '0;
  logic          ret = 1'b0;
  logic [NP-1:0] grant_o;
  logic [2:0]    grant_idx_o;
  logic          locked_o;
  logic [CW-1:0] credits_o;
  logic          credit_err_o;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit m_locked;
  int m_owner;
  int m_last;
  int m_credits;
  bit m_err;

  out_port_alloc #(
    .NUM_PORTS    (NP),
    .CREDIT_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req),
    .tail_i          (tail),
    .credit_return_i (ret),
    .grant_o         (grant_o),
    .grant_idx_o     (grant_idx_o),
    .locked_o        (locked_o),
    .credits_o       (credits_o),
    .credit_err_o    (credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked  = 0;
    m_owner   = 0;
    m_last    = NP - 1;
    m_credits = DEPTH;
    m_err     = 0;
  endtask

  // Expected granted port, 7 when none: closest requester after the last winner.
  function automatic int exp_idx();
    int best, bestd, d;
    if (m_credits == 0) return 7;
    if (m_locked) return req[m_owner] ? m_owner : 7;
    best  = 7;
    bestd = NP + 1;
    for (int p = 0; p < NP; p++) begin
      d = (p - m_last - 1 + 2 * NP) % NP;
      if (req[p] && d < bestd) begin
        best  = p;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [NP-1:0] exp_oh();
    int g;
    g = exp_idx();
    return (g == 7) ? '0 : NP'(1 << g);
  endfunction

  // One clock: compute the model's next state from the current inputs, then commit at the edge.
  task automatic advance();
    int g, n_owner, n_last, n_cred;
    bit xfer, n_locked, n_err;
    g        = exp_idx();
    xfer     = (g != 7);
    n_locked = m_locked;
    n_owner  = m_owner;
    n_last   = m_last;
    n_err    = m_err;
`ifdef OUT_ALLOC_CREDIT_CHECK_EN
    if (ret && m_credits == DEPTH && !xfer) n_err = 1;
    if (m_locked && ((req & ~(NP'(1) << m_owner)) != 0) && tail[m_owner] && !req[m_owner]) n_err = 1;
`endif
    if (xfer) begin
      if (!m_locked) begin
        if (tail[g]) n_last = g;
        else begin
          n_locked = 1;
          n_owner  = g;
        end
      end else if (tail[m_owner]) begin
        n_locked = 0;
        n_last   = m_owner;
      end
    end
    n_cred = m_credits - int'(xfer) + int'(ret);
    if (n_cred > DEPTH) n_cred = DEPTH;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      m_locked  = n_locked;
      m_owner   = n_owner;
      m_last    = n_last;
      m_credits = n_cred;
      m_err     = n_err;
    end
    #1;
  endtask

  task automatic test_reset();
    req = '0; tail = '0; ret = 0;
    #2;
    vectors++; if (grant_o !== 5'b0) begin miscompares++; $display("FAIL reset_grant: got %b want 00000", grant_o); end
    vectors++; if (grant_idx_o !== 3'b111) begin miscompares++; $display("FAIL reset_idx: got %0d want 7", grant_idx_o); end
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    vectors++; if (credits_o !== 3'(DEPTH)) begin miscompares++; $display("FAIL reset_credits: got %0d want %0d", credits_o, DEPTH); end
    vectors++; if (credit_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", credit_err_o); end
    advance();
  endtask

  task automatic test_rr_singles();
    int tbl[4] = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) begin
      req = 5'b00110; tail = 5'b00110; ret = 1;
      #2;
      vectors++; if (grant_idx_o !== 3'(tbl[i])) begin miscompares++; $display("FAIL rr_idx c%0d: got %0d want %0d", i, grant_idx_o, tbl[i]); end
      vectors++; if (credits_o !== 3'(DEPTH)) begin miscompares++; $display("FAIL rr_credits c%0d: got %0d want %0d", i, credits_o, DEPTH); end
      advance();
    end
  endtask

  task automatic test_packet_lock();
    int  idx_tbl[4] = '{3, 3, 3, 0};
    bit  lck_tbl[4] = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      req  = (i < 3) ? 5'b01001 : 5'b00001;
      tail = (i == 2) ? 5'b01000 : ((i == 3) ? 5'b00001 : 5'b00000);
      ret  = 1;
      #2;
      vectors++; if (grant_idx_o !== 3'(idx_tbl[i])) begin miscompares++; $display("FAIL lock_idx c%0d: got %0d want %0d", i, grant_idx_o, idx_tbl[i]); end
      vectors++; if (locked_o !== lck_tbl[i]) begin miscompares++; $display("FAIL lock_locked c%0d: got %b want %b", i, locked_o, lck_tbl[i]); end
      advance();
    end
  endtask

  task automatic test_credit_exhaust();
    int want;
    for (int i = 0; i < 6; i++) begin
      req = 5'b10000; tail = 5'b10000; ret = 0;
      #2;
      want = (i < 4) ? 4 : 7;
      vectors++; if (grant_idx_o !== 3'(want)) begin miscompares++; $display("FAIL exh_idx c%0d: got %0d want %0d", i, grant_idx_o, want); end
      want = (i < 4) ? DEPTH - i : 0;
      vectors++; if (credits_o !== 3'(want)) begin miscompares++; $display("FAIL exh_credits c%0d: got %0d want %0d", i, credits_o, want); end
      advance();
    end
    req = '0; tail = '0; ret = 1;
    #2;
    advance();
    req = 5'b10000; tail = 5'b10000; ret = 0;
    #2;
    vectors++; if (grant_idx_o !== 3'd4) begin miscompares++; $display("FAIL exh_regrant: got %0d want 4", grant_idx_o); end
    vectors++; if (credits_o !== 3'd1) begin miscompares++; $display("FAIL exh_one_credit: got %0d want 1", credits_o); end
    advance();
    req = '0; tail = '0;
    #2;
    vectors++; if (credits_o !== 3'd0) begin miscompares++; $display("FAIL exh_drained: got %0d want 0", credits_o); end
  endtask

  task automatic test_same_cycle();
    req = '0; tail = '0; ret = 1;
    #2;
    advance();
    req = 5'b10000; tail = 5'b10000; ret = 1;
    #2;
    vectors++; if (grant_idx_o !== 3'd4) begin miscompares++; $display("FAIL same_idx: got %0d want 4", grant_idx_o); end
    advance();
    ret = 0;
    #2;
    vectors++; if (credits_o !== 3'd1) begin miscompares++; $display("FAIL same_credits: got %0d want 1", credits_o); end
    vectors++; if (grant_idx_o !== 3'd4) begin miscompares++; $display("FAIL same_next_grant: got %0d want 4", grant_idx_o); end
    advance();
    req = '0; tail = '0; ret = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      advance();
    end
    #2;
    vectors++; if (credits_o !== 3'(DEPTH)) begin miscompares++; $display("FAIL same_refill: got %0d want %0d", credits_o, DEPTH); end
  endtask

  task automatic test_reset_mid_packet();
    req = 5'b00100; tail = '0; ret = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++; if (grant_idx_o !== 3'd2) begin miscompares++; $display("FAIL mid_body c%0d: got %0d want 2", i, grant_idx_o); end
      advance();
    end
    #2;
    vectors++; if (locked_o !== 1'b1 || credits_o !== 3'd1) begin miscompares++; $display("FAIL mid_pre: got locked=%b credits=%0d want locked=1 credits=1", locked_o, credits_o); end
    rst = 0;
    advance();
    rst = 1;
    req = 5'b11111; tail = 5'b11111;
    #2;
    vectors++; if (locked_o !== 1'b0) begin miscompares++; $display("FAIL mid_locked: got %b want 0", locked_o); end
    vectors++; if (credits_o !== 3'(DEPTH)) begin miscompares++; $display("FAIL mid_credits: got %0d want %0d", credits_o, DEPTH); end
    vectors++; if (grant_idx_o !== 3'd0) begin miscompares++; $display("FAIL mid_first: got %0d want 0", grant_idx_o); end
    advance();
  endtask

  task automatic test_credit_err();
    bit want_err;
`ifdef OUT_ALLOC_CREDIT_CHECK_EN
    want_err = 1;
`else
    want_err = 0;
`endif
    req = '0; tail = '0; ret = 1;
    #2;
    advance();
    #2;
    advance();
    ret = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++; if (credit_err_o !== want_err) begin miscompares++; $display("FAIL err_sticky c%0d: got %b want %b", i, credit_err_o, want_err); end
      vectors++; if (credits_o !== 3'(DEPTH)) begin miscompares++; $display("FAIL err_credits c%0d: got %0d want %0d", i, credits_o, DEPTH); end
      advance();
    end
    rst = 0;
    advance();
    rst = 1;
    #2;
    vectors++; if (credit_err_o !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b want 0", credit_err_o); end
    advance();
  endtask

  task automatic test_random();
    logic [NP-1:0] eo;
    int            ei;
    for (int i = 0; i < 400; i++) begin
      req  = NP'($urandom);
      tail = NP'($urandom) & NP'($urandom);
      ret  = ($urandom_range(0, 2) != 0);
      #2;
      eo = exp_oh();
      ei = exp_idx();
      vectors++; if (grant_o !== eo) begin miscompares++; $display("FAIL rnd_grant c%0d: got %b want %b", i, grant_o, eo); end
      vectors++; if (grant_idx_o !== 3'(ei)) begin miscompares++; $display("FAIL rnd_idx c%0d: got %0d want %0d", i, grant_idx_o, ei); end
      vectors++; if (locked_o !== m_locked) begin miscompares++; $display("FAIL rnd_locked c%0d: got %b want %b", i, locked_o, m_locked); end
      vectors++; if (int'(credits_o) !== m_credits) begin miscompares++; $display("FAIL rnd_credits c%0d: got %0d want %0d", i, credits_o, m_credits); end
      vectors++; if (credit_err_o !== m_err) begin miscompares++; $display("FAIL rnd_err c%0d: got %b want %b", i, credit_err_o, m_err); end
      advance();
    end
  endtask

  initial begin
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    test_reset();
    test_rr_singles();
    test_packet_lock();
    test_credit_exhaust();
    test_same_cycle();
    test_reset_mid_packet();
    test_credit_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
